// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for N requesters: registered one-hot grant, lock while the owner holds req,
// zero-bubble handoff on release. Define ARB_HOLD_LIMIT_EN to force rotation after MAX_HOLD cycles.
module rr_arbiter_n #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [N-1:0]                      req_i,
   output logic [N-1:0]                      gnt_o,
   output logic                              gnt_valid_o,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_id_o,
   output logic                              preempt_o
);
   localparam int ID_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

   if (N < 1 || N > 32) begin : g_bad_n
      $error("rr_arbiter_n: N must be in 1..32");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_arbiter_n: MAX_HOLD must be in 2..255");
   end

   typedef enum logic {IDLE, OWNED} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [7:0]        hold_q, hold_d;
   logic              pre_q, pre_d;

   logic [N-1:0]      cand;
   logic              win_found;
   logic [ID_W-1:0]   win_id;
   logic [ID_W-1:0]   win_ptr;
   logic [N-1:0]      win_oh;
   logic              take;
   int                idx;

   // Masking the current owner out lets the same scan serve release and forced rotation.
   assign cand = req_i & ~gnt_q;

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N) idx = idx - N;
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

   assign win_ptr = (win_id == ID_W'(N - 1)) ? '0 : win_id + 1'b1;

   always_comb begin
      win_oh         = '0;
      win_oh[win_id] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      pre_d   = 1'b0;
      take    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_found) take = 1'b1;
         end
         OWNED: begin
            if (req_i[id_q]) begin
`ifdef ARB_HOLD_LIMIT_EN
               if (hold_q >= HOLD_LIM && win_found) begin
                  take  = 1'b1;
                  pre_d = 1'b1;
               end else if (hold_q < HOLD_LIM) begin
                  hold_d = hold_q + 8'd1;
               end
`else
               if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
`endif
            end else if (win_found) begin
               take = 1'b1;
            end else begin
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (take) begin
         gnt_d   = win_oh;
         id_d    = win_id;
         ptr_d   = win_ptr;
         hold_d  = 8'd1;
         state_d = OWNED;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         id_q    <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         pre_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         pre_q   <= pre_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_valid_o = (state_q == OWNED);
   assign gnt_id_o    = id_q;
   assign preempt_o   = pre_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Bench for rr_arbiter_n: vector table plus hand sequences for reset, hold limit and N=1.
module tb_rr_arbiter_n;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       vld;
   logic [1:0] id;
   logic       pre;
   logic       req1;
   logic       gnt1;
   logic       vld1;
   logic       id1;
   logic       pre1;

   always #5 clk = ~clk;

   rr_arbiter_n #(.N(4), .MAX_HOLD(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req),
      .gnt_o(gnt), .gnt_valid_o(vld), .gnt_id_o(id), .preempt_o(pre)
   );

   rr_arbiter_n #(.N(1), .MAX_HOLD(4)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req1),
      .gnt_o(gnt1), .gnt_valid_o(vld1), .gnt_id_o(id1), .preempt_o(pre1)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       vld;
      logic       pre;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

`ifdef ARB_HOLD_LIMIT_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   function automatic vec_t mk(logic [3:0] r, logic [3:0] g, logic [1:0] i, logic v, logic p);
      vec_t e;
      e.req = r; e.gnt = g; e.id = i; e.vld = v; e.pre = p;
      return e;
   endfunction

   task automatic check(string name, vec_t a, vec_t e);
      n_vec++;
      if ({a.gnt, a.id, a.vld, a.pre} !== {e.gnt, e.id, e.vld, e.pre}) begin
         n_bad++;
         $display("FAIL %s: got gnt=%b id=%0d vld=%b pre=%b, want gnt=%b id=%0d vld=%b pre=%b",
                  name, a.gnt, a.id, a.vld, a.pre, e.gnt, e.id, e.vld, e.pre);
      end
   endtask

   function automatic vec_t act4();
      return mk(req, gnt, id, vld, pre);
   endfunction

   function automatic vec_t act1();
      return mk({3'b0, req1}, {3'b0, gnt1}, {1'b0, id1}, vld1, pre1);
   endfunction

   // Drive on the falling edge, queue the expectation, compare just after the next rising edge.
   task automatic apply(string name, vec_t e);
      vec_t x;
      @(negedge clk);
      req = e.req;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      check(name, act4(), x);
   endtask

   task automatic apply1(string name, vec_t e);
      vec_t x;
      @(negedge clk);
      req1 = e.req[0];
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      check(name, act1(), x);
   endtask

   initial begin
      vec_t x;
      // Fairness from reset: each owner drops req for one cycle after two grant cycles.
      tbl.push_back(mk(4'b1111, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(mk(4'b1111, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(mk(4'b1110, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(mk(4'b1111, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(mk(4'b1101, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(mk(4'b1111, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(mk(4'b1011, 4'b1000, 2'd3, 1, 0));
      tbl.push_back(mk(4'b1111, 4'b1000, 2'd3, 1, 0));
      tbl.push_back(mk(4'b0111, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 0, 0));
      // Zero-bubble handoff 1 -> 2, then wrap from ptr=3 skipping to 0.
      tbl.push_back(mk(4'b0010, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(mk(4'b0110, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(mk(4'b0100, 4'b0100, 2'd2, 1, 0));
      tbl.push_back(mk(4'b0011, 4'b0001, 2'd0, 1, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 2'd0, 0, 0));
      // Idle keeps last owner id; simultaneous requests resolved from ptr.
      tbl.push_back(mk(4'b1000, 4'b1000, 2'd3, 1, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 2'd3, 0, 0));
      tbl.push_back(mk(4'b0110, 4'b0010, 2'd1, 1, 0));
      tbl.push_back(mk(4'b0000, 4'b0000, 2'd1, 0, 0));

      req = 4'b0; req1 = 1'b0; rst_n = 1'b0;
      #12;
      check("reset4", act4(), mk(4'b0, 4'b0, 2'd0, 0, 0));
      check("reset1", act1(), mk(4'b0, 4'b0, 2'd0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) apply($sformatf("tbl[%0d]", i), tbl[i]);

      // Asynchronous reset between edges while owner 2 holds.
      apply("pre_rst_grant", mk(4'b0100, 4'b0100, 2'd2, 1, 0));
      #3;
      rst_n = 1'b0;
      #1;
      check("async_rst", act4(), mk(4'b0100, 4'b0, 2'd0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b1000;
      exp_q.push_back(mk(4'b1000, 4'b1000, 2'd3, 1, 0));
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      check("post_rst_grant", act4(), x);

      // Sole requester keeps the grant well past MAX_HOLD in both builds.
      @(negedge clk);
      req = 4'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) apply($sformatf("solo[%0d]", i), mk(4'b0001, 4'b0001, 2'd0, 1, 0));
      apply("solo_rel", mk(4'b0000, 4'b0000, 2'd0, 0, 0));

      // Contended hold: owner 0 granted, req[2] joins a cycle later.
      apply("hold[0]", mk(4'b0001, 4'b0001, 2'd0, 1, 0));
      for (int i = 1; i < 4; i++) apply($sformatf("hold[%0d]", i), mk(4'b0101, 4'b0001, 2'd0, 1, 0));
      if (HOLD_EN) begin
         apply("preempt", mk(4'b0101, 4'b0100, 2'd2, 1, 1));
         apply("post_preempt", mk(4'b0101, 4'b0100, 2'd2, 1, 0));
         apply("handback", mk(4'b0001, 4'b0001, 2'd0, 1, 0));
      end else begin
         for (int i = 0; i < 100; i++)
            apply($sformatf("nolimit[%0d]", i), mk(4'b0101, 4'b0001, 2'd0, 1, 0));
      end

      // N=1: grant follows req with one cycle of latency.
      apply1("n1[0]", mk(4'b0001, 4'b0001, 2'd0, 1, 0));
      apply1("n1[1]", mk(4'b0001, 4'b0001, 2'd0, 1, 0));
      apply1("n1[2]", mk(4'b0000, 4'b0000, 2'd0, 0, 0));
      apply1("n1[3]", mk(4'b0001, 4'b0001, 2'd0, 1, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
